pc_unit: RTL

Parametrised program-counter unit for the pipelined MIPS CPU, the successor to the plain PC register. It holds the fetch address and applies increment, stall, branch/jump redirect, exception vectoring, and halt/resume control. It buffers a redirect that arrives during a stall and detects misaligned targets. It sits at the head of the IF stage and drives the instruction-memory address and the IF/ID PC+4 path.

---
 rtl/pc_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: sequential fetch, stall, branch/jump
// redirect with one-entry pending buffer, exception vectoring and halt/resume.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter int               ALIGN_BITS   = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             misalign_reg, misalign_next;

  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             target_bad;

  // Branch beats jump when both resolve in the same cycle.
  assign redirect   = br_taken | jmp;
  assign target     = br_taken ? br_target : jmp_target;
  assign target_bad = redirect && ((target & ALIGN_MASK) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_VECTOR;
      epc_reg         <= '0;
      pend_target_reg <= '0;
      pend_valid_reg  <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      epc_reg         <= epc_next;
      pend_target_reg <= pend_target_next;
      pend_valid_reg  <= pend_valid_next;
      misalign_reg    <= misalign_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    epc_next         = epc_reg;
    pend_target_next = pend_target_reg;
    pend_valid_next  = pend_valid_reg;
    misalign_next    = 1'b0;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (exc) begin
          pc_next         = EXC_VECTOR;
          epc_next        = pc_reg;
          pend_valid_next = 1'b0;
        end else if (target_bad) begin
          pc_next         = EXC_VECTOR;
          epc_next        = pc_reg;
          misalign_next   = 1'b1;
          pend_valid_next = 1'b0;
        end else if (halt) begin
          state_next = HALT;
          if (redirect) begin
            pend_target_next = target;
            pend_valid_next  = 1'b1;
          end
        end else if (redirect) begin
          if (stall) begin
            pend_target_next = target;
            pend_valid_next  = 1'b1;
          end else begin
            pc_next         = target;
            pend_valid_next = 1'b0;
          end
        end else if (!stall) begin
          // Buffered redirect takes the first stall-free slot.
          if (pend_valid_reg) begin
            pc_next         = pend_target_reg;
            pend_valid_next = 1'b0;
          end else begin
            pc_next = pc_reg + WIDTH'(STEP);
          end
        end
      end
      HALT: begin
        if (exc) begin
          state_next      = RUN;
          pc_next         = EXC_VECTOR;
          epc_next        = pc_reg;
          pend_valid_next = 1'b0;
        end else if (resume) begin
          state_next      = RUN;
          pend_valid_next = 1'b0;
          if (pend_valid_reg) pc_next = pend_target_reg;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign pc_out   = pc_reg;
  assign pc_plus  = pc_reg + WIDTH'(STEP);
  assign pc_valid = (state_reg == RUN);
  assign epc      = epc_reg;
  assign misalign = misalign_reg;

endmodule
